// File: rtl/iambic_keyer_gen2.sv
// Iambic (mode A/B) and straight-key Morse keyer with PTT lead, hang time
// and dash weighting; every duration is counted in 1 ms prescaler ticks.
module iambic_keyer_gen2 #(
    parameter int CLKS_PER_MS = 48000,
    parameter int DOT_W       = 10,
    parameter int DEB_MS      = 5
) (
    input  logic             IF_clk,
    input  logic             IF_rst,
    input  logic             paddle_dot_n,
    input  logic             paddle_dash_n,
    input  logic [1:0]       keyer_mode,
    input  logic             keys_reversed,
    input  logic [DOT_W-1:0] dot_ms,
    input  logic [6:0]       weight,
    input  logic [7:0]       ptt_delay_ms,
    input  logic [9:0]       hang_ms,
    output logic             key_on,
    output logic             tx_en,
    output logic             tick_1ms,
    output logic             elem_start
);

    localparam int PW = $clog2(CLKS_PER_MS);
    localparam int DW = DOT_W + 3;
    localparam int CW = (DW > 10) ? DW : 10;
    localparam int BW = $clog2(DEB_MS + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_DOT,
        S_DASH,
        S_SPACE,
        S_HANG,
        S_STRAIGHT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            tick_q, tick_d;
    logic [BW-1:0]   deb_q, deb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic            last_q, last_d;
    logic            mem_q, mem_d;
    logic            key_on_q, key_on_d;
    logic            tx_en_q, tx_en_d;
    logic            es_q, es_d;

    logic                 dot_s, dash_s;
    logic                 key_deb_s;
    logic [DOT_W-1:0]     dot_eff_s;
    logic signed [DW-1:0] dash_raw_s;
    logic [DW-1:0]        dash_len_s;
    logic [CW-1:0]        target_s;
    logic                 done_s;
    logic                 straight_live_s, straight_q_s;
    logic                 cur_dash_s, same_low_s, opp_low_s, mem_now_s;
    logic                 go_s, next_dash_s;

    // Free-running 1 ms prescaler
    always_comb begin
        pre_d  = pre_q + PW'(1);
        tick_d = 1'b0;
        if (pre_q == PW'(CLKS_PER_MS - 1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Paddle swap and straight-key debounce (count saturates at DEB_MS)
    always_comb begin
        dot_s  = keys_reversed ? ~paddle_dash_n : ~paddle_dot_n;
        dash_s = keys_reversed ? ~paddle_dot_n  : ~paddle_dash_n;
        deb_d  = deb_q;
        if (tick_q) begin
            if (!dot_s) begin
                deb_d = '0;
            end else if (deb_q != BW'(DEB_MS)) begin
                deb_d = deb_q + BW'(1);
            end else begin
                deb_d = deb_q;
            end
        end else begin
            deb_d = deb_q;
        end
        key_deb_s = (deb_d == BW'(DEB_MS));
    end

    // Element lengths and the per-state tick target
    always_comb begin
        dot_eff_s  = (dot_ms == '0) ? DOT_W'(1) : dot_ms;
        dash_raw_s = signed'(DW'(dot_eff_s) * DW'(3) + DW'(weight) - DW'(50));
        if (dash_raw_s < signed'(DW'(dot_eff_s))) begin
            dash_len_s = DW'(dot_eff_s);
        end else begin
            dash_len_s = unsigned'(dash_raw_s);
        end
        case (state_q)
            S_LEAD:          target_s = CW'(ptt_delay_ms);
            S_DOT, S_SPACE:  target_s = CW'(dot_eff_s);
            S_DASH:          target_s = CW'(dash_len_s);
            S_HANG:          target_s = CW'(hang_ms);
            default:         target_s = '0;
        endcase
        done_s = tick_q && ((cnt_q + CW'(1)) == target_s);
    end

    // Paddle roles relative to the element in progress (SPACE uses the last one)
    always_comb begin
        straight_live_s = (keyer_mode[1] == keyer_mode[0]);
        straight_q_s    = (mode_q[1] == mode_q[0]);
        cur_dash_s      = (state_q == S_DASH) || ((state_q != S_DOT) && last_q);
        same_low_s      = cur_dash_s ? dash_s : dot_s;
        opp_low_s       = cur_dash_s ? dot_s : dash_s;
        mem_now_s       = mem_q || ((mode_q == 2'b10) && opp_low_s);
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick_q ? (cnt_q + CW'(1)) : cnt_q;
        mode_d      = mode_q;
        last_d      = last_q;
        mem_d       = mem_q;
        go_s        = 1'b0;
        next_dash_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                mode_d = keyer_mode;
                cnt_d  = '0;
                mem_d  = 1'b0;
                if (straight_live_s) begin
                    if (key_deb_s) begin
                        state_d = S_STRAIGHT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (dot_s || dash_s) begin
                    last_d = !dot_s;
                    if (ptt_delay_ms == 8'd0) begin
                        state_d = dot_s ? S_DOT : S_DASH;
                    end else begin
                        state_d = S_LEAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEAD: begin
                if (done_s) begin
                    state_d = last_q ? S_DASH : S_DOT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_LEAD;
                end
            end
            S_DOT, S_DASH: begin
                mem_d = mem_now_s;
                if (done_s) begin
                    state_d = S_SPACE;
                    last_d  = (state_q == S_DASH);
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SPACE: begin
                mem_d = mem_now_s;
                if (done_s) begin
                    cnt_d = '0;
                    if (mem_now_s) begin
                        go_s        = 1'b1;
                        next_dash_s = !cur_dash_s;
                    end else if (same_low_s) begin
                        go_s        = 1'b1;
                        next_dash_s = cur_dash_s;
                    end else if (opp_low_s) begin
                        go_s        = 1'b1;
                        next_dash_s = !cur_dash_s;
                    end else begin
                        go_s = 1'b0;
                    end
                    if (go_s) begin
                        state_d = next_dash_s ? S_DASH : S_DOT;
                        last_d  = next_dash_s;
                        mem_d   = 1'b0;
                    end else begin
                        state_d = S_HANG;
                    end
                end else begin
                    state_d = S_SPACE;
                end
            end
            S_HANG: begin
                mem_d = 1'b0;
                if (straight_q_s) begin
                    if (key_deb_s) begin
                        state_d = S_STRAIGHT;
                        cnt_d   = '0;
                    end else if ((hang_ms == 10'd0) || done_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HANG;
                    end
                end else if (dot_s || dash_s) begin
                    state_d = dot_s ? S_DOT : S_DASH;
                    last_d  = !dot_s;
                    cnt_d   = '0;
                end else if ((hang_ms == 10'd0) || done_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HANG;
                end
            end
            S_STRAIGHT: begin
                if (!key_deb_s) begin
                    state_d = S_HANG;
                    cnt_d   = '0;
                end else begin
                    state_d = S_STRAIGHT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they change on the transition edge
    always_comb begin
        key_on_d = (state_d == S_DOT) || (state_d == S_DASH) || (state_d == S_STRAIGHT);
        tx_en_d  = (state_d != S_IDLE);
        es_d     = key_on_d && !key_on_q;
    end

    // State and output registers
    always_ff @(posedge IF_clk or posedge IF_rst) begin
        if (IF_rst) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            tick_q   <= 1'b0;
            deb_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            last_q   <= 1'b0;
            mem_q    <= 1'b0;
            key_on_q <= 1'b0;
            tx_en_q  <= 1'b0;
            es_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            last_q   <= last_d;
            mem_q    <= mem_d;
            key_on_q <= key_on_d;
            tx_en_q  <= tx_en_d;
            es_q     <= es_d;
        end
    end

    assign key_on     = key_on_q;
    assign tx_en      = tx_en_q;
    assign tick_1ms   = tick_q;
    assign elem_start = es_q;

endmodule

// File: tb/tb_iambic_keyer_gen2.sv
// Bench for iambic_keyer_gen2: tick-sampled {tx_en,key_on} traces are compared
// run-by-run against timelines built from the keying rules.
module tb_iambic_keyer_gen2;

    localparam int CPM = 4;

    logic       IF_clk = 1'b0;
    logic       IF_rst;
    logic       paddle_dot_n, paddle_dash_n;
    logic [1:0] keyer_mode;
    logic       keys_reversed;
    logic [9:0] dot_ms;
    logic [6:0] weight;
    logic [7:0] ptt_delay_ms;
    logic [9:0] hang_ms;
    logic       key_on, tx_en, tick_1ms, elem_start;

    iambic_keyer_gen2 #(.CLKS_PER_MS(CPM), .DOT_W(10), .DEB_MS(5)) dut (
        .IF_clk(IF_clk), .IF_rst(IF_rst),
        .paddle_dot_n(paddle_dot_n), .paddle_dash_n(paddle_dash_n),
        .keyer_mode(keyer_mode), .keys_reversed(keys_reversed),
        .dot_ms(dot_ms), .weight(weight), .ptt_delay_ms(ptt_delay_ms), .hang_ms(hang_ms),
        .key_on(key_on), .tx_en(tx_en), .tick_1ms(tick_1ms), .elem_start(elem_start)
    );

    always #5 IF_clk = ~IF_clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] trace_q[$];
    int         es_cnt = 0;

    // Record output state at every tick and count elem_start pulses
    always @(negedge IF_clk) begin
        if (!IF_rst && tick_1ms) trace_q.push_back({tx_en, key_on});
        if (!IF_rst && elem_start) es_cnt++;
    end

    logic [1:0] exp_code[$];
    int         exp_len[$];
    logic [1:0] obs_code[$];
    int         obs_len[$];
    int         base_tr, base_es, scn_ticks;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge IF_clk); #1;
            n++;
        end while (!tick_1ms && n < 4 * CPM);
        if (!tick_1ms) check("tick_timeout", int'(tick_1ms), 1);
        scn_ticks++;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    function automatic int eff_dot(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int dash_ticks(input int d, input int w);
        int e, r;
        e = eff_dot(d);
        r = 3 * e + w - 50;
        return (r < e) ? e : r;
    endfunction

    task automatic exp_add(input logic [1:0] c, input int n);
        if (n > 0) begin
            if (exp_code.size() > 0 && exp_code[exp_code.size()-1] == c)
                exp_len[exp_len.size()-1] += n;
            else begin
                exp_code.push_back(c);
                exp_len.push_back(n);
            end
        end
    endtask

    task automatic set_par(input logic [1:0] m, input logic rev, input int d, input int w,
                           input int ptt, input int hang);
        keyer_mode    = m;
        keys_reversed = rev;
        dot_ms        = d[9:0];
        weight        = w[6:0];
        ptt_delay_ms  = ptt[7:0];
        hang_ms       = hang[9:0];
    endtask

    task automatic start_scn();
        base_tr   = trace_q.size();
        base_es   = es_cnt;
        scn_ticks = 0;
        exp_code.delete();
        exp_len.delete();
    endtask

    task automatic end_scn(input string tag, input int elems);
        int sum, n;
        sum = 0;
        foreach (exp_len[i]) sum += exp_len[i];
        exp_code.push_back(2'b00);
        exp_len.push_back(0);
        while (scn_ticks < sum + 2) wait_tick();
        obs_code.delete();
        obs_len.delete();
        for (int i = base_tr; i < trace_q.size(); i++) begin
            if (obs_code.size() > 0 && obs_code[obs_code.size()-1] == trace_q[i])
                obs_len[obs_len.size()-1]++;
            else begin
                obs_code.push_back(trace_q[i]);
                obs_len.push_back(1);
            end
        end
        if (obs_code.size() > 0 && obs_code[obs_code.size()-1] == 2'b00)
            obs_len[obs_len.size()-1] = 0;
        check({tag, "_nruns"}, obs_code.size(), exp_code.size());
        n = (obs_code.size() < exp_code.size()) ? obs_code.size() : exp_code.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_code%0d", tag, i), int'(obs_code[i]), int'(exp_code[i]));
            check($sformatf("%s_len%0d", tag, i), obs_len[i], exp_len[i]);
        end
        check({tag, "_elems"}, es_cnt - base_es, elems);
    endtask

    // Single tap of one paddle, released after one tick
    task automatic tap(input string tag, input logic [1:0] m, input logic rev, input logic is_dash,
                       input int d, input int w, input int ptt, input int hang);
        set_par(m, rev, d, w, ptt, hang);
        wait_tick();
        start_scn();
        exp_add(2'b00, 1);
        exp_add(2'b10, ptt);
        exp_add(2'b11, is_dash ? dash_ticks(d, w) : eff_dot(d));
        exp_add(2'b10, eff_dot(d) + hang);
        if (is_dash != rev) paddle_dash_n = 1'b0;
        else                paddle_dot_n  = 1'b0;
        @(posedge IF_clk); #1;
        check({tag, "_txen_now"}, int'(tx_en), 1);
        wait_tick();
        paddle_dot_n  = 1'b1;
        paddle_dash_n = 1'b1;
        end_scn(tag, 1);
    endtask

    initial begin
        int n;
        IF_rst = 1'b1;
        paddle_dot_n = 1'b1;
        paddle_dash_n = 1'b1;
        set_par(2'b01, 1'b0, 3, 50, 2, 5);
        repeat (6) @(posedge IF_clk);
        #1;
        check("rst_key_on", int'(key_on), 0);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_tick", int'(tick_1ms), 0);
        check("rst_elem_start", int'(elem_start), 0);
        IF_rst = 1'b0;
        n = 0;
        do begin @(posedge IF_clk); #1; n++; end while (!tick_1ms && n < 20);
        check("first_tick", n, CPM);

        // Dot held for one tick with a 2-tick lead and 5-tick hang
        tap("req023", 2'b01, 1'b0, 1'b0, 3, 50, 2, 5);

        // Squeeze then release during the first dot: mode A
        set_par(2'b01, 1'b0, 2, 50, 0, 3);
        wait_tick(); start_scn();
        exp_add(2'b00, 1); exp_add(2'b11, 2); exp_add(2'b10, 5);
        paddle_dot_n = 1'b0; paddle_dash_n = 1'b0;
        wait_tick();
        paddle_dot_n = 1'b1; paddle_dash_n = 1'b1;
        end_scn("sqzA", 1);

        // Same squeeze in mode B; the mode change mid-element must not apply
        set_par(2'b10, 1'b0, 2, 50, 0, 3);
        wait_tick(); start_scn();
        exp_add(2'b00, 1); exp_add(2'b11, 2); exp_add(2'b10, 2);
        exp_add(2'b11, 6); exp_add(2'b10, 5);
        paddle_dot_n = 1'b0; paddle_dash_n = 1'b0;
        wait_tick();
        paddle_dot_n = 1'b1; paddle_dash_n = 1'b1;
        keyer_mode = 2'b01;
        end_scn("sqzB", 2);

        // Dash weighting extremes and dot_ms = 0
        tap("w0", 2'b01, 1'b0, 1'b1, 10, 0, 0, 2);
        tap("w100", 2'b10, 1'b0, 1'b1, 10, 100, 0, 2);
        tap("dot0", 2'b01, 1'b0, 1'b0, 0, 50, 0, 2);

        // Straight key: 4 low, 1 high, 6 low, then released
        set_par(2'b00, 1'b0, 3, 50, 4, 3);
        wait_tick(); start_scn();
        exp_add(2'b00, 10); exp_add(2'b11, 2); exp_add(2'b10, 3);
        paddle_dot_n = 1'b0;
        wait_ticks(4);
        paddle_dot_n = 1'b1;
        wait_tick();
        paddle_dot_n = 1'b0;
        wait_ticks(6);
        paddle_dot_n = 1'b1;
        end_scn("straight", 1);

        // Press during HANG: new element without LEAD, tx_en stays high
        set_par(2'b01, 1'b0, 2, 50, 2, 5);
        wait_tick(); start_scn();
        exp_add(2'b00, 1); exp_add(2'b10, 2); exp_add(2'b11, 2); exp_add(2'b10, 5);
        exp_add(2'b11, 2); exp_add(2'b10, 7);
        paddle_dot_n = 1'b0;
        wait_tick();
        paddle_dot_n = 1'b1;
        wait_ticks(8);
        paddle_dot_n = 1'b0;
        wait_tick();
        paddle_dot_n = 1'b1;
        end_scn("hangpress", 2);

        // Reset asserted in the middle of a dash
        set_par(2'b01, 1'b0, 3, 50, 0, 2);
        wait_tick();
        paddle_dash_n = 1'b0;
        wait_ticks(3);
        check("middash_key_on", int'(key_on), 1);
        #2 IF_rst = 1'b1;
        #1;
        check("rstmid_key_on", int'(key_on), 0);
        check("rstmid_tx_en", int'(tx_en), 0);
        paddle_dash_n = 1'b1;
        repeat (3) @(posedge IF_clk);
        #1;
        check("rstmid_tick", int'(tick_1ms), 0);
        IF_rst = 1'b0;
        n = 0;
        do begin @(posedge IF_clk); #1; n++; end while (!tick_1ms && n < 20);
        check("rstmid_first_tick", n, CPM);
        check("rstmid_tx_after", int'(tx_en), 0);

        // Randomised single taps
        for (int i = 0; i < 8; i++) begin
            tap($sformatf("rnd%0d", i), 2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 100)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
